// File: rtl/mach_timer_if.sv
// Register bus between the interconnect (master) and the machine timer (slave).
// Word-addressed accesses with byte enables; read data returns one clock after the address.
interface mach_timer_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [31:0] data_o;

    modport master (
        output addr_i,
        output data_i,
        output sel_i,
        output we_i,
        input  data_o
    );

    modport slave (
        input  addr_i,
        input  data_i,
        input  sel_i,
        input  we_i,
        output data_o
    );
endinterface

// File: rtl/mach_timer.sv
// Machine timer: 64-bit free-running mtime with prescaler, 64-bit mtimecmp,
// CTRL register (EN, IE, PEND) and a registered level timer interrupt.
// Optional feature macro: MTIMER_SNAPSHOT_EN -- a read of MTIME_LO latches
// mtime[63:32] into a shadow that later MTIME_HI reads return.
module mach_timer #(
    parameter int unsigned PRESCALE = 1,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    mach_timer_if.slave  bus,
    output logic         irq_o
);

    localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_MTIME_LO = 3'd1,
        REG_MTIME_HI = 3'd2,
        REG_CMP_LO   = 3'd3,
        REG_CMP_HI   = 3'd4
    } reg_idx_e;

    logic          en_q, en_d;
    logic          ie_q, ie_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   cmp_q, cmp_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   data_q, data_d;
    logic          irq_q, irq_d;
`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0]   shadow_q, shadow_d;
`endif

    logic [2:0]    idx;
    logic          pend;
    logic          tick;
    logic          unused_addr;

    assign idx         = bus.addr_i[4:2];
    assign unused_addr = ^{bus.addr_i[31:5], bus.addr_i[1:0]};
    assign pend        = (mtime_q >= cmp_q);
    assign tick        = en_q && (pre_q == PRE_MAX);

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

    // Next-state: register writes, prescaler, mtime increment, read mux and interrupt.
    always_comb begin
        // NOTE: every _d starts from its hold value, so no branch can leave it unassigned and infer a latch.
        en_d    = en_q;
        ie_d    = ie_q;
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        pre_d   = pre_q;
        data_d  = '0;
        irq_d   = ie_q & pend;
`ifdef MTIMER_SNAPSHOT_EN
        shadow_d = shadow_q;
`endif

        // Prescaler runs only while enabled; disabling clears it.
        if (en_q) pre_d = tick ? '0 : pre_q + PW'(1);
        else      pre_d = '0;

        // A write to either mtime half wins over the increment for the whole 64 bits.
        if (bus.we_i && idx == REG_MTIME_LO) begin
            mtime_d[31:0] = merge(mtime_q[31:0], bus.data_i, bus.sel_i);
        end else if (bus.we_i && idx == REG_MTIME_HI) begin
            mtime_d[63:32] = merge(mtime_q[63:32], bus.data_i, bus.sel_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (bus.we_i) begin
            case (idx)
                REG_CTRL: begin
                    if (bus.sel_i[0]) begin
                        en_d = bus.data_i[0];
                        ie_d = bus.data_i[1];
                    end
                end
                REG_CMP_LO: cmp_d[31:0]  = merge(cmp_q[31:0],  bus.data_i, bus.sel_i);
                REG_CMP_HI: cmp_d[63:32] = merge(cmp_q[63:32], bus.data_i, bus.sel_i);
                default: ;
            endcase
        end

`ifdef MTIMER_SNAPSHOT_EN
        // LO read freezes the upper half; HI writes keep the shadow coherent.
        if (!bus.we_i && idx == REG_MTIME_LO) shadow_d = mtime_q[63:32];
        if (bus.we_i && idx == REG_MTIME_HI)  shadow_d = merge(mtime_q[63:32], bus.data_i, bus.sel_i);
`endif

        // Read mux samples register values from before this edge's updates.
        case (idx)
            REG_CTRL:     data_d = {29'd0, pend, ie_q, en_q};
            REG_MTIME_LO: data_d = mtime_q[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            REG_MTIME_HI: data_d = shadow_q;
`else
            REG_MTIME_HI: data_d = mtime_q[63:32];
`endif
            REG_CMP_LO:   data_d = cmp_q[31:0];
            REG_CMP_HI:   data_d = cmp_q[63:32];
            default:      data_d = '0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            mtime_q <= '0;
            cmp_q   <= CMP_RST;
            pre_q   <= '0;
            data_q  <= '0;
            irq_q   <= 1'b0;
`ifdef MTIMER_SNAPSHOT_EN
            shadow_q <= '0;
`endif
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            pre_q   <= pre_d;
            data_q  <= data_d;
            irq_q   <= irq_d;
`ifdef MTIMER_SNAPSHOT_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    assign bus.data_o = data_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_mach_timer.sv
// Self-checking bench for mach_timer (default parameters).
module tb_mach_timer;

    logic clk = 1'b0;
    logic rst;
    logic irq;

    mach_timer_if bus_if ();

    mach_timer dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if),
        .irq_o (irq)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, clock edge, settle 1 time unit past the edge.
    task automatic bus_cycle(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] sel);
        bus_if.we_i   = we;
        bus_if.addr_i = addr;
        bus_if.data_i = data;
        bus_if.sel_i  = sel;
        @(posedge clk);
        #1;
        bus_if.we_i   = 1'b0;
        bus_if.addr_i = 32'h14;
        bus_if.sel_i  = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel = 4'hF);
        bus_cycle(1'b1, addr, data, sel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 32'h14, 32'h0, 4'h0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        bus_cycle(1'b0, addr, 32'h0, 4'h0);
        e = exp_q.pop_front();
        check(name, bus_if.data_o, e);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] snap_hi_exp;

        // Register-map vectors applied with the counter stopped.
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hFFFF_FFFF};
        vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 32'h0000_001C, 32'h0, 4'h0, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'hFFFF_FFE4, 32'h0, 4'h0, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'h0000_000C, 32'hAABB_CCDD, 4'b0010, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'hFFFF_CCFF};
        vecs[10] = '{1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'h0000_0000};
        vecs[12] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF8, 4'hF, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0000_0000};
        vecs[14] = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 32'h0};

        bus_if.we_i   = 1'b0;
        bus_if.addr_i = 32'h14;
        bus_if.data_i = 32'h0;
        bus_if.sel_i  = 4'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_o", bus_if.data_o, 32'h0);
        chk_irq("reset_irq", 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].data, vecs[i].sel);
            else            rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        rd("cmp_lo_restored", 32'h0C, 32'hFFFF_FFFF);
        chk_irq("irq_idle", 1'b0);

        // Counting at PRESCALE=1 and freeze on EN clear.
        wr(32'h00, 32'h1);
        idle(10);
        rd("count10", 32'h04, 32'h0000_000A);
        wr(32'h00, 32'h0);
        rd("frozen_a", 32'h04, 32'h0000_000C);
        rd("frozen_b", 32'h04, 32'h0000_000C);
        rd("frozen_hi", 32'h08, 32'h0);

        // Carry from LO into HI.
        wr(32'h04, 32'hFFFF_FFFE);
        wr(32'h08, 32'h0);
        wr(32'h00, 32'h1);
        idle(2);
        wr(32'h00, 32'h0);
        rd("carry_lo", 32'h04, 32'h0000_0001);
        rd("carry_hi", 32'h08, 32'h0000_0001);

        // Full 64-bit wrap.
        wr(32'h04, 32'hFFFF_FFFF);
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h00, 32'h1);
        wr(32'h00, 32'h0);
        rd("wrap_lo", 32'h04, 32'h0);
        rd("wrap_hi", 32'h08, 32'h0);

        // Interrupt on compare match.
        wr(32'h0C, 32'h20);
        wr(32'h10, 32'h0);
        wr(32'h00, 32'h3);
        for (int k = 1; k <= 33; k++) begin
            idle(1);
            if (k == 32) chk_irq("irq_before_match", 1'b0);
            if (k == 33) chk_irq("irq_after_match", 1'b1);
        end
        rd("ctrl_pend", 32'h00, 32'h7);
        wr(32'h0C, 32'h100);
        chk_irq("irq_hold_on_cmp_write", 1'b1);
        idle(1);
        chk_irq("irq_cleared_by_cmp", 1'b0);
        wr(32'h00, 32'h1);
        wr(32'h0C, 32'h0);
        idle(2);
        chk_irq("irq_masked", 1'b0);
        rd("ctrl_pend_masked", 32'h00, 32'h5);

        // mtime write during counting takes priority over the increment.
        wr(32'h04, 32'h1234_5678);
        rd("mtime_write_exact", 32'h04, 32'h1234_5678);
        wr(32'h04, 32'h0000_00EE, 4'b0001);
        rd("mtime_lane_write", 32'h04, 32'h1234_56EE);
        rd("mtime_hi_held", 32'h08, 32'h0);

        // LO-then-HI read across a carry.
        wr(32'h00, 32'h0);
        wr(32'h04, 32'hFFFF_FFFF);
        wr(32'h08, 32'h0);
        wr(32'h00, 32'h1);
        rd("snap_lo", 32'h04, 32'hFFFF_FFFF);
        idle(5);
`ifdef MTIMER_SNAPSHOT_EN
        snap_hi_exp = 32'h0;
`else
        snap_hi_exp = 32'h1;
`endif
        rd("snap_hi", 32'h08, snap_hi_exp);

        // Reset mid-count with the interrupt asserted.
        wr(32'h0C, 32'h0);
        wr(32'h10, 32'h0);
        wr(32'h00, 32'h3);
        idle(1);
        chk_irq("irq_before_reset", 1'b1);
        rst = 1'b1;
        idle(1);
        chk_irq("irq_after_reset", 1'b0);
        check("data_o_after_reset", bus_if.data_o, 32'h0);
        rst = 1'b0;
        rd("ctrl_after_reset", 32'h00, 32'h0);
        rd("cmp_lo_after_reset", 32'h0C, 32'hFFFF_FFFF);
        rd("cmp_hi_after_reset", 32'h10, 32'hFFFF_FFFF);
        rd("mtime_lo_after_reset", 32'h04, 32'h0);
        rd("mtime_hi_after_reset", 32'h08, 32'h0);
        chk_irq("irq_stays_low", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mach_timer.md
Name: mach_timer

Overview:
- Memory-mapped machine timer slave on the SoC OBI interconnect, with the interconnect base/mask decode already applied.
- Holds a 64-bit free-running counter (mtime), a 64-bit compare register (mtimecmp) and a control register.
- Drives a level timer interrupt into the core's irq_timer_i input.
- Register access is simple word-addressed with byte enables; read data is returned one clock after the address.

Parameters:
- PRESCALE, 1, clock cycles per mtime increment (legal range ≥1).
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- addr_i  in  32  byte address; only addr_i[4:2] decoded, all other bits ignored
- data_i  in  32  write data
- sel_i  in  4  byte enables; bit k covers data_i[8k+7:8k]
- we_i  in  1  write strobe, one write per cycle while high
- data_o  out  32  registered read data
- irq_o  out  1  timer interrupt, level, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Register map (word offsets):
  - 0x00 CTRL: bit0 EN (count enable, RW), bit1 IE (interrupt enable, RW), bit2 PEND (RO, = mtime ≥ mtimecmp, unsigned), bits[31:3] read 0.
  - 0x04 MTIME_LO, 0x08 MTIME_HI.
  - 0x0C CMP_LO, 0x10 CMP_HI.
  - Offsets 0x14–0x1C: read 0, writes ignored.
- Reset state: CTRL=0, mtime=0, mtimecmp=CMP_RST, prescale counter=0, data_o=0, irq_o=0.
- Writes: on a clock edge with we_i=1, each byte lane with sel_i bit set is written to the addressed register; unselected bytes hold. Writes to PEND are ignored.
- Read path: every edge, data_o <= value of register at addr_i[4:2], sampled before that edge's updates. This gives 1-cycle latency. Reads have no side effects, except under the optional feature.
- Prescaler:
  - While EN=1, the prescale counter counts 0..PRESCALE-1.
  - On the cycle it equals PRESCALE-1 it returns to 0 and mtime increments by 1.
  - With PRESCALE=1, mtime increments every cycle.
  - EN=0 holds mtime and clears the prescale counter.
- Wrap: mtime 64'hFFFF_FFFF_FFFF_FFFF + 1 -> 0, with no flag.
- Write vs increment in the same cycle: a write to MTIME_LO or MTIME_HI suppresses the increment for the whole 64-bit register. Written bytes take data_i; all other bytes hold their old value, with no carry applied.
- Interrupt:
  - irq_o <= IE & (mtime ≥ mtimecmp), evaluated on current register values each edge.
  - Level output; cleared only by raising mtimecmp, lowering mtime, or clearing IE.
  - Effective one cycle after the condition changes.
- Compare is full 64-bit unsigned.
- Reset asserted mid-count: all state returns to reset values at that edge, and irq_o drops the next cycle.

Optional Feature:
- Macro: MTIMER_SNAPSHOT_EN.
- When defined:
  - A read access to MTIME_LO (addr decode = 0x04 with we_i=0) also latches the current mtime[63:32] into a 32-bit shadow register.
  - Subsequent MTIME_HI reads return the shadow, so LO-then-HI reads form a consistent 64-bit value across a carry.
  - Shadow resets to 0.
  - Writes to MTIME_HI update both the live register and the shadow.
- When undefined: MTIME_HI reads return live mtime[63:32] and no shadow exists.

Test Plan:
- Reset, then read all offsets: CTRL=0, MTIME_LO/HI=0, CMP_LO/HI=0xFFFFFFFF, offset 0x14=0, irq_o=0; data_o valid 1 cycle after addr_i.
- PRESCALE=1, write CTRL=0x1, hold 10 cycles, read MTIME_LO -> 10 ±1 (exact value per write/read timing, e.g. 0x0000000A); clear EN -> value frozen on repeated reads.
- Write MTIME_LO=0xFFFFFFFE and MTIME_HI=0, EN=1, run 3 cycles -> MTIME_HI=1, MTIME_LO=0x00000001. Then write all ones to both halves and run 1 cycle -> 0/0 (wrap).
- CMP=0x20, IE=1, EN=1 from mtime=0 -> irq_o rises one cycle after mtime reaches 0x20 and PEND reads 1. Write CMP_LO=0x100 -> irq_o falls next cycle. With IE=0 and the condition true -> irq_o stays 0, PEND reads 1.
- Byte-enable write: sel_i=4'b0010, data_i=0xAABBCCDD to CMP_LO (reset value) -> reads 0xFFFFCCFF. A write to MTIME_LO in a counting cycle -> exactly the written value, no increment.
- With MTIMER_SNAPSHOT_EN, mtime=0x0_FFFFFFFF counting: read LO, wait 5 cycles, read HI -> HI=0 (shadow). Without the macro, the same sequence reads HI=1.
